// File: rtl/prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs7_checker
// Purpose  : Self-synchronising PRBS-7 (1 + x^3 + x^7) serial checker with
//            lock detection, windowed loss-of-lock and saturating error count.
// Options  : PRBS7_CHK_BITCNT_EN adds bit_count (bits checked while locked).
// Revision : 1.0 - initial release
// ============================================================================
module prbs7_checker #(
    parameter int LOCK_THRESH   = 8,
    parameter int WINDOW        = 32,
    parameter int UNLOCK_THRESH = 4,
    parameter int ERR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             data_in,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
`ifdef PRBS7_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int c_MC_W = $clog2(LOCK_THRESH + 1);
    localparam int c_WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_WE_W = $clog2(UNLOCK_THRESH + 1);

    localparam logic [0:0] c_SEARCH = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [7:1]        r_hist;
    logic [2:0]        r_fill;
    logic [c_MC_W-1:0] r_match_cnt;
    logic [c_WC_W-1:0] r_win_cnt;
    logic [c_WE_W-1:0] r_win_errs;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_count;

    logic              w_pred;
    logic              w_fill_done;
    logic              w_match;
    logic              w_lock_hit;
    logic              w_mismatch;
    logic              w_wrap;
    logic              w_unlock_hit;
    logic [c_WE_W-1:0] w_win_errs_nxt;

    assign w_pred      = r_hist[7] ^ r_hist[3];
    assign w_fill_done = (r_fill == 3'd7);
    // An all-zero history predicts zero forever, so it must never count as a match.
    assign w_match     = w_fill_done && (|r_hist) && (data_in == w_pred);
    assign w_lock_hit  = en && (r_state == c_SEARCH) && w_match &&
                         (r_match_cnt == c_MC_W'(LOCK_THRESH - 1));
    assign w_mismatch  = en && (r_state == c_LOCKED) && (data_in != w_pred);
    assign w_wrap      = (r_win_cnt == c_WC_W'(WINDOW - 1));
    assign w_win_errs_nxt = w_wrap ? c_WE_W'(w_mismatch)
                                   : r_win_errs + c_WE_W'(w_mismatch);
    assign w_unlock_hit = en && (r_state == c_LOCKED) &&
                          (w_win_errs_nxt >= c_WE_W'(UNLOCK_THRESH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_SEARCH: if (w_lock_hit)   w_state_nxt = c_LOCKED;
            c_LOCKED: if (w_unlock_hit) w_state_nxt = c_SEARCH;
            default:                    w_state_nxt = c_SEARCH;
        endcase
    end

    always_comb begin
        locked = (r_state == c_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_errs  <= '0;
            r_err       <= 1'b0;
        end else if (en) begin
            r_err <= w_mismatch;
            if (r_state == c_SEARCH) begin
                r_hist <= {r_hist[6:1], data_in};
                if (!w_fill_done) begin
                    r_fill <= r_fill + 3'd1;
                end else if (w_match && !w_lock_hit) begin
                    r_match_cnt <= r_match_cnt + c_MC_W'(1);
                end else begin
                    r_match_cnt <= '0;
                end
                if (w_lock_hit) begin
                    r_win_cnt  <= '0;
                    r_win_errs <= '0;
                end
            end else begin
                // Free-running local generator: one bad bit yields one error only.
                r_hist     <= {r_hist[6:1], w_pred};
                r_win_cnt  <= w_wrap ? '0 : r_win_cnt + c_WC_W'(1);
                r_win_errs <= w_win_errs_nxt;
                if (w_unlock_hit) begin
                    r_fill      <= '0;
                    r_match_cnt <= '0;
                end
            end
        end else begin
            r_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_err_count <= '0;
        end else if (w_mismatch && (r_err_count != {ERR_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    assign err       = r_err;
    assign err_count = r_err_count;

`ifdef PRBS7_CHK_BITCNT_EN
    logic [31:0] r_bit_count;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_bit_count <= '0;
        end else if (en && (r_state == c_LOCKED) && (r_bit_count != 32'hFFFF_FFFF)) begin
            r_bit_count <= r_bit_count + 32'd1;
        end
    end

    assign bit_count = r_bit_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs7_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs7_checker
// Purpose  : Directed, self-checking bench for prbs7_checker against a
//            sequence-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs7_checker;

    localparam int c_LOCK_THRESH   = 8;
    localparam int c_WINDOW        = 32;
    localparam int c_UNLOCK_THRESH = 4;
    localparam int c_ERR_W         = 4;
    localparam int c_CNT_MAX       = (1 << c_ERR_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               data_in = 1'b0;
    logic               clr = 1'b0;
    logic               locked;
    logic               err;
    logic [c_ERR_W-1:0] err_count;
`ifdef PRBS7_CHK_BITCNT_EN
    logic [31:0]        bit_count;
`endif

    int         n_checks = 0;
    int         n_pass = 0;
    int         n_err_pulses = 0;
    logic [6:0] gen = 7'b0000001;

    prbs7_checker #(
        .LOCK_THRESH  (c_LOCK_THRESH),
        .WINDOW       (c_WINDOW),
        .UNLOCK_THRESH(c_UNLOCK_THRESH),
        .ERR_W        (c_ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_in  (data_in),
        .clr      (clr),
        .locked   (locked),
        .err      (err),
        .err_count(err_count)
`ifdef PRBS7_CHK_BITCNT_EN
        ,
        .bit_count(bit_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transmit-side generator: x[n] = x[n-7] ^ x[n-3], oldest bit in gen[6].
    function automatic logic gen_bit();
        logic b;
        b   = gen[6];
        gen = {gen[5:0], gen[6] ^ gen[2]};
        return b;
    endfunction

    task automatic send(input logic b);
        @(negedge clk);
        rst     = 1'b1;
        clr     = 1'b0;
        en      = 1'b1;
        data_in = b;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Reference model: tracks the sequence the checker should be predicting.
    logic   mq[$];
    int     m_fill, m_run, m_since, m_werrs, m_cnt;
    logic   m_locked = 1'b0;
    logic   m_err = 1'b0;
    longint m_bits;
    logic   s_rst, s_en, s_d, s_clr, p, mis, nz;

    always @(posedge clk) begin
        s_rst = rst; s_en = en; s_d = data_in; s_clr = clr;
        if (!s_rst) begin
            mq.delete();
            m_fill = 0; m_run = 0; m_since = 0; m_werrs = 0; m_cnt = 0; m_bits = 0;
            m_locked = 1'b0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (s_en) begin
                if (!m_locked && m_fill < 7) begin
                    m_fill++;
                    mq.push_back(s_d);
                end else begin
                    p  = mq[mq.size()-7] ^ mq[mq.size()-3];
                    nz = 1'b0;
                    for (int k = 1; k <= 7; k++) nz = nz | mq[mq.size()-k];
                    if (!m_locked) begin
                        m_run = (s_d == p && nz) ? m_run + 1 : 0;
                        mq.push_back(s_d);
                        if (m_run == c_LOCK_THRESH) begin
                            m_locked = 1'b1; m_since = 0; m_werrs = 0; m_run = 0;
                        end
                    end else begin
                        mis = (s_d != p);
                        mq.push_back(p);
                        m_bits++;
                        m_err = mis;
                        if (mis && m_cnt < c_CNT_MAX) m_cnt++;
                        if (m_since % c_WINDOW == c_WINDOW - 1) m_werrs = mis ? 1 : 0;
                        else m_werrs += mis ? 1 : 0;
                        m_since++;
                        if (m_werrs >= c_UNLOCK_THRESH) begin
                            m_locked = 1'b0; m_fill = 0; m_run = 0;
                        end
                    end
                end
                if (mq.size() > 16) void'(mq.pop_front());
            end
            if (s_clr) begin
                m_cnt  = 0;
                m_bits = 0;
            end
        end
        #1;
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err", 32'(err), 32'(m_err));
        chk("err_count", 32'(err_count), m_cnt);
`ifdef PRBS7_CHK_BITCNT_EN
        chk("bit_count", bit_count, m_bits[31:0]);
`endif
        if (err === 1'b1) n_err_pulses++;
    end

    logic b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(err_count), 0);
        @(negedge clk) rst = 1'b1;

        // Clean lock: rises on the 15th enabled edge
        for (int i = 0; i < 200; i++) begin
            send(gen_bit());
            if (i == 13 || i == 14) begin
                after_edge();
                chk("lock_edge", 32'(locked), (i == 14) ? 1 : 0);
            end
        end
        after_edge();
        chk("lock_hold", 32'(locked), 1);
        chk("lock_cnt", 32'(err_count), 0);
        chk("lock_no_err", n_err_pulses, 0);

        // Single corrupted bit; 103 bits leaves the window aligned to position 0
        n_err_pulses = 0;
        for (int i = 0; i < 103; i++) begin
            b = gen_bit();
            send((i == 60) ? ~b : b);
            if (i == 60) begin
                after_edge();
                chk("single_err_pulse", 32'(err), 1);
            end
        end
        after_edge();
        chk("single_cnt", 32'(err_count), 1);
        chk("single_pulses", n_err_pulses, 1);
        chk("single_locked", 32'(locked), 1);

        @(negedge clk); en = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("clr_cnt", 32'(err_count), 0);

        // Inverted stream: unlock on the 4th mismatch, then relock
        for (int i = 0; i < 4; i++) begin
            send(~gen_bit());
            after_edge();
            chk("unlock_edge", 32'(locked), (i < 3) ? 1 : 0);
        end
        chk("unlock_cnt", 32'(err_count), 4);
        for (int i = 0; i < 15; i++) begin
            send(gen_bit());
            if (i >= 13) begin
                after_edge();
                chk("relock_edge", 32'(locked), (i == 14) ? 1 : 0);
            end
        end

        // One error per window for 20 windows: saturates, stays locked
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < 32; i++) begin
                b = gen_bit();
                send((i == 5) ? ~b : b);
            end
        end
        after_edge();
        chk("sat_cnt", 32'(err_count), c_CNT_MAX);
        chk("sat_locked", 32'(locked), 1);

        // clr wins over a coincident mismatch, err still pulses
        @(negedge clk); en = 1'b1; data_in = ~gen_bit(); clr = 1'b1;
        after_edge();
        chk("clr_err_pulse", 32'(err), 1);
        chk("clr_prio_cnt", 32'(err_count), 0);

        // en gating with garbage on data_in
        n_err_pulses = 0;
        for (int i = 0; i < 10; i++) send(gen_bit());
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en = 1'b0;
            data_in = 1'($urandom_range(0, 1));
        end
        after_edge();
        chk("gate_locked", 32'(locked), 1);
        chk("gate_err", 32'(err), 0);
        for (int i = 0; i < 20; i++) send(gen_bit());
        after_edge();
        chk("gate_resume_locked", 32'(locked), 1);
        chk("gate_pulses", n_err_pulses, 0);

        // Reset while locked, then reacquire
        send(~gen_bit());
        after_edge();
        chk("pre_rst_cnt", 32'(err_count), 1);
        @(negedge clk); rst = 1'b0; en = 1'b1; data_in = 1'b1;
        after_edge();
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_cnt", 32'(err_count), 0);
        for (int i = 0; i < 15; i++) begin
            send(gen_bit());
            if (i >= 13) begin
                after_edge();
                chk("rst_relock_edge", 32'(locked), (i == 14) ? 1 : 0);
            end
        end

        // All-zero input never locks
        @(negedge clk); rst = 1'b0; en = 1'b1; data_in = 1'b0;
        after_edge();
        for (int i = 0; i < 100; i++) send(1'b0);
        after_edge();
        chk("zero_locked", 32'(locked), 0);
        chk("zero_cnt", 32'(err_count), 0);

        @(negedge clk); en = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prbs7_checker.md
Name: prbs7_checker

Overview:
- Serial PRBS-7 checker. It is the receive end of the team's 7-bit PRBS generator and uses the same polynomial, 1 + X^3 + X^7.
- Recurrence: x[n] = x[n-7] XOR x[n-3].
- Self-synchronises to the incoming bitstream, declares lock, then counts bit errors against a free-running local copy of the sequence.
- Sits on the receive side of loopback and link bring-up tests.

Parameters:
- LOCK_THRESH, 8: consecutive correct predictions required in SEARCH before LOCKED.
- WINDOW, 32: length in enabled bits of the loss-of-lock observation window.
- UNLOCK_THRESH, 4: mismatches within one window that force a return to SEARCH.
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset (0 = reset)
- en  input  1  bit-valid qualifier; data_in is sampled only on edges where en=1
- data_in  input  1  received serial PRBS bit
- clr  input  1  synchronous clear of err_count; active high
- locked  output  1  high while in LOCKED
- err  output  1  one-cycle pulse per mismatched bit while LOCKED
- err_count  output  ERR_W  saturating count of LOCKED mismatches

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=SEARCH; hist=0; fill=0; match_cnt=0; win_cnt=0; win_errs=0.
  - Outputs: locked=0, err=0, err_count=0.
  - Reset overrides every other input, including mid-lock.
- en=0: all state holds; err=0 on that edge.
- hist[7:1]: hist[k] holds the bit received k enabled samples earlier. Predicted bit pred = hist[7] XOR hist[3].
- SEARCH, first 7 enabled bits (fill<7):
  - hist shifts in data_in; fill increments.
  - No comparison is made.
- SEARCH, fill=7:
  - Compare data_in with pred. A match counts only if hist != 0, so an all-zero input never locks.
  - On a match, match_cnt increments; otherwise match_cnt=0.
  - hist shifts in data_in.
  - When the LOCK_THRESH-th consecutive match is sampled, go to LOCKED on that edge: locked=1 from that edge, win_cnt=0, win_errs=0.
  - With defaults, locked rises on the 15th enabled edge of a clean stream.
- LOCKED:
  - hist shifts in pred, not data_in. The local generator free-runs, so one corrupted bit produces exactly one error.
  - Mismatch (data_in != pred): err=1 on that edge's registered output. err_count increments and saturates at 2^ERR_W-1. win_errs increments.
  - win_cnt counts 0..WINDOW-1 and then wraps. On wrap, win_errs reloads to 0, or to 1 if the wrap bit itself mismatched.
  - If win_errs reaches UNLOCK_THRESH, go to SEARCH on that edge: locked=0, fill=0, match_cnt=0, hist retained but refilled.
- Latency: err and locked are registered, with no further pipeline. The comparison result is visible immediately after the sampling edge.
- err_count:
  - Persists across unlock/relock.
  - Cleared only by rst or clr.
  - clr has priority over a coincident mismatch: count becomes 0, err still pulses.
- Errors are never counted in SEARCH.

Optional Feature:
- Macro: PRBS7_CHK_BITCNT_EN.
- When defined:
  - Adds output bit_count [31:0]: count of enabled bits sampled while LOCKED, saturating at 2^32-1.
  - Cleared by rst and by clr.
  - Enables BER = err_count/bit_count.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Lock, defaults: generator seeded 7'b0000001, en=1 every cycle, 200 bits -> locked=1 after the 15th edge; err never pulses; err_count=0.
- Single-bit error: invert bit 60 of the locked stream -> exactly one err pulse on that bit's edge; err_count=1; locked stays 1.
- All-zero input for 100 enabled cycles -> locked stays 0; err_count=0.
- Unlock: after lock, feed the inverted PRBS (4 mismatches within 32 bits) -> locked falls on the 4th mismatch edge; err_count=4; clean PRBS afterwards relocks within 15 bits.
- Saturation and clr, ERR_W=4: while locked, inject 1 error per 32-bit window for 20 windows -> err_count saturates at 15 and locked stays 1; pulse clr -> err_count=0 next edge.
- Gating and reset: hold en=0 mid-stream for 10 cycles, then resume -> no errors and locked held. Assert rst=0 for 1 edge while locked -> locked=0, err_count=0; lock reacquired after 15 bits.
